// File: rtl/dmem_access.sv
// Data-memory access unit for the MEM stage: request/ack bus transaction, load
// formatting, LL/SC link tracking and misalignment detection.
module dmem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemHalf,
  input  logic        MemByte,
  input  logic        MemSignExtend,
  input  logic        LLSC,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  output logic [31:0] MemReadData,
  output logic        StallController,
  output logic        AddrError,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // state | meaning
  // IDLE  | nothing outstanding; decode the MEM-stage instruction
  // WAIT  | bus_req held high until bus_ack
  // DONE  | MemReadData valid; wait for the pipeline to advance
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, nextState;
  logic        access, isStore, isByte, isHalf, misaligned, scFail;
  logic        launch, scReject, waitAck;
  logic [3:0]  beNext;
  logic [31:0] wdataNext;
  logic        linkValid;
  logic [29:0] linkAddr;
  logic [1:0]  latLo;
  logic        latByte, latHalf, latSign, latLl, latSc;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;

  // A simultaneous read and write request is treated as a read.
  assign access     = MemRead | MemWrite;
  assign isStore    = MemWrite & ~MemRead;
  assign isByte     = MemByte;
  assign isHalf     = MemHalf & ~MemByte;
  assign misaligned = access & ((isHalf & ALUResult[0]) |
                      (~isByte & ~isHalf & (ALUResult[1:0] != 2'b00)));
  assign scFail     = isStore & LLSC & ~(linkValid & (linkAddr == ALUResult[31:2]));
  assign waitAck    = (state == WAIT) & bus_ack;

  always_comb begin
    nextState       = state;
    StallController = 1'b0;
    AddrError       = 1'b0;
    launch          = 1'b0;
    scReject        = 1'b0;
    case (state)
      IDLE: begin
        if (misaligned) begin
          AddrError = 1'b1;
        end else if (access && !Flush) begin
          StallController = 1'b1;
          if (scFail) begin
            scReject  = 1'b1;
            nextState = DONE;
          end else begin
            launch    = 1'b1;
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        StallController = 1'b1;
        if (bus_ack) nextState = Flush ? IDLE : DONE;
      end
      DONE: begin
        if (!Stall) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    if (isByte) begin
      beNext    = 4'b0001 << ALUResult[1:0];
      wdataNext = {4{ReadData2[7:0]}};
    end else if (isHalf) begin
      beNext    = ALUResult[1] ? 4'b1100 : 4'b0011;
      wdataNext = {2{ReadData2[15:0]}};
    end else begin
      beNext    = 4'b1111;
      wdataNext = ReadData2;
    end
  end

  always_comb begin
    case (latLo)
      2'd0:    byteSel = bus_rdata[7:0];
      2'd1:    byteSel = bus_rdata[15:8];
      2'd2:    byteSel = bus_rdata[23:16];
      default: byteSel = bus_rdata[31:24];
    endcase
    halfSel = latLo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    if (latByte)
      loadData = {{24{latSign & byteSel[7]}}, byteSel};
    else if (latHalf)
      loadData = {{16{latSign & halfSel[15]}}, halfSel};
    else
      loadData = bus_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'd0;
      bus_be      <= 4'd0;
      bus_wdata   <= 32'd0;
      MemReadData <= 32'd0;
      linkValid   <= 1'b0;
      linkAddr    <= 30'd0;
      latLo       <= 2'd0;
      latByte     <= 1'b0;
      latHalf     <= 1'b0;
      latSign     <= 1'b0;
      latLl       <= 1'b0;
      latSc       <= 1'b0;
    end else begin
      state <= nextState;
      if (launch) begin
        bus_req   <= 1'b1;
        bus_we    <= isStore;
        bus_addr  <= {ALUResult[31:2], 2'b00};
        bus_be    <= beNext;
        bus_wdata <= wdataNext;
        latLo     <= ALUResult[1:0];
        latByte   <= isByte;
        latHalf   <= isHalf;
        latSign   <= MemSignExtend;
        latLl     <= MemRead & LLSC;
        latSc     <= isStore & LLSC;
      end
      // A flushed transaction still completes on the bus, but its result is dropped.
      if (waitAck) begin
        bus_req <= 1'b0;
        if (!Flush) MemReadData <= bus_we ? {31'd0, latSc} : loadData;
        if (latLl) begin
          linkValid <= 1'b1;
          linkAddr  <= bus_addr[31:2];
        end else if (latSc) begin
          linkValid <= 1'b0;
        end else if (bus_we && (linkAddr == bus_addr[31:2])) begin
          linkValid <= 1'b0;
        end
      end
      if (scReject) MemReadData <= 32'd0;
      if (Flush) linkValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_access.sv
// Self-checking bench for dmem_access: scoreboard of expected MemReadData,
// inline bus responder with programmable ack delay.
module tb_dmem_access;

  logic        clk, rst_n, Stall, Flush;
  logic        MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC;
  logic [31:0] ALUResult, ReadData2, MemReadData;
  logic        StallController, AddrError;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int          errCnt = 0;
  int          chkCnt = 0;
  logic [31:0] expQ[$];
  logic [31:0] lastExp = 32'd0;

  dmem_access dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemHalf(MemHalf), .MemByte(MemByte),
    .MemSignExtend(MemSignExtend), .LLSC(LLSC), .ALUResult(ALUResult),
    .ReadData2(ReadData2), .MemReadData(MemReadData),
    .StallController(StallController), .AddrError(AddrError),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [1:0] a,
                                          input logic half, input logic sx);
    logic [31:0] s;
    int sh;
    sh = half ? (a[1] ? 16 : 0) : 8 * int'(a);
    s  = w >> sh;
    if (half) return sx ? {{16{s[15]}}, s[15:0]} : {16'd0, s[15:0]};
    return sx ? {{24{s[7]}}, s[7:0]} : {24'd0, s[7:0]};
  endfunction

  task automatic clearInputs();
    MemRead = 0; MemWrite = 0; MemHalf = 0; MemByte = 0; MemSignExtend = 0; LLSC = 0;
    ALUResult = 0; ReadData2 = 0; Flush = 0; Stall = 0;
  endtask

  task automatic doAccess(input string tag, input logic rd, wr, hf, by, sx, ll,
                          input logic [31:0] addr, wd, rdata, input int waits,
                          input logic expReq, expWe, input logic [31:0] expAddr,
                          input logic [3:0] expBe, input logic [31:0] expWd,
                          input logic [31:0] expRd, input int hold);
    int stalls, reqCyc;
    logic done;
    logic [31:0] exp;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; MemHalf = hf; MemByte = by; MemSignExtend = sx;
    LLSC = ll; ALUResult = addr; ReadData2 = wd;
    expQ.push_back(expRd);
    stalls = 0; reqCyc = 0; done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      #1;
      if (c == 0) checkVal({tag, " addrerr"}, {31'd0, AddrError}, 32'd0);
      if (StallController) begin
        stalls++;
        if (bus_req) begin
          reqCyc++;
          if (reqCyc == 1) begin
            checkVal({tag, " addr"}, bus_addr, expAddr);
            checkVal({tag, " be"}, {28'd0, bus_be}, {28'd0, expBe});
            checkVal({tag, " we"}, {31'd0, bus_we}, {31'd0, expWe});
            if (expWe) checkVal({tag, " wdata"}, bus_wdata, expWd);
          end
          if (reqCyc == waits + 1) begin
            bus_ack = 1; bus_rdata = rdata;
          end
        end
      end else begin
        done = 1;
      end
      if (!done) begin
        @(posedge clk); #1 bus_ack = 0;
        @(negedge clk);
      end
    end
    checkVal({tag, " done"}, {31'd0, done}, 32'd1);
    checkVal({tag, " stalls"}, stalls, expReq ? 2 + waits : 1);
    checkVal({tag, " reqseen"}, {31'd0, reqCyc != 0}, {31'd0, expReq});
    if (expQ.size() == 0) begin
      checkVal({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      exp = expQ.pop_front();
      checkVal({tag, " rdata"}, MemReadData, exp);
      lastExp = exp;
    end
    for (int h = 0; h < hold; h++) begin
      Stall = 1; bus_ack = 1;
      @(posedge clk); @(negedge clk); #1;
      checkVal({tag, " hold stall"}, {31'd0, StallController}, 32'd0);
      checkVal({tag, " hold req"}, {31'd0, bus_req}, 32'd0);
      checkVal({tag, " hold rdata"}, MemReadData, lastExp);
    end
    bus_ack = 0;
    clearInputs();
    @(posedge clk);
  endtask

  task automatic misalignTest(input string tag, input logic hf, input logic [31:0] addr);
    @(negedge clk);
    MemRead = 1; MemHalf = hf; ALUResult = addr;
    #1;
    checkVal({tag, " addrerr"}, {31'd0, AddrError}, 32'd1);
    checkVal({tag, " stall"}, {31'd0, StallController}, 32'd0);
    @(posedge clk); @(negedge clk); #1;
    checkVal({tag, " req"}, {31'd0, bus_req}, 32'd0);
    checkVal({tag, " addrerr2"}, {31'd0, AddrError}, 32'd1);
    clearInputs();
  endtask

  initial begin
    rst_n = 0; bus_ack = 0; bus_rdata = 0;
    clearInputs();
    #12;
    checkVal("rst req", {31'd0, bus_req}, 32'd0);
    checkVal("rst stall", {31'd0, StallController}, 32'd0);
    checkVal("rst addrerr", {31'd0, AddrError}, 32'd0);
    checkVal("rst rdata", MemReadData, 32'd0);
    checkVal("rst addr", bus_addr, 32'd0);
    checkVal("rst be", {28'd0, bus_be}, 32'd0);
    @(negedge clk); rst_n = 1;

    doAccess("lw", 1,0,0,0,0,0, 32'h100, 0, 32'hDEADBEEF, 1, 1,0, 32'h100, 4'hF, 0, 32'hDEADBEEF, 0);
    doAccess("lb", 1,0,0,1,1,0, 32'h103, 0, 32'h80FF0000, 0, 1,0, 32'h100, 4'h8, 0, 32'hFFFFFF80, 0);
    doAccess("lbu",1,0,0,1,0,0, 32'h103, 0, 32'h80FF0000, 0, 1,0, 32'h100, 4'h8, 0, 32'h00000080, 0);
    doAccess("lh", 1,0,1,0,1,0, 32'h102, 0, 32'h80FF0000, 0, 1,0, 32'h100, 4'hC, 0, 32'hFFFF80FF, 0);
    doAccess("sb", 0,1,0,1,0,0, 32'h201, 32'hAB, 0, 0, 1,1, 32'h200, 4'h2, 32'hABABABAB, 0, 0);
    doAccess("sh", 0,1,1,0,0,0, 32'h202, 32'h1234, 0, 2, 1,1, 32'h200, 4'hC, 32'h12341234, 0, 0);
    doAccess("sw", 0,1,0,0,0,0, 32'h204, 32'hCAFE0001, 0, 0, 1,1, 32'h204, 4'hF, 32'hCAFE0001, 0, 0);

    for (int a = 0; a < 4; a++) begin
      logic [3:0] beTab [4];
      beTab = '{4'h1, 4'h2, 4'h4, 4'h8};
      doAccess($sformatf("lb lane%0d", a), 1,0,0,1,1,0, 32'h900 + a, 0, 32'h7F80C301, 0,
               1,0, 32'h900, beTab[a], 0, refLoad(32'h7F80C301, 2'(a), 1'b0, 1'b1), 0);
    end
    for (int a = 0; a < 4; a += 2) begin
      doAccess($sformatf("lhu lane%0d", a), 1,0,1,0,0,0, 32'h900 + a, 0, 32'h8001FFFE, 0,
               1,0, 32'h900, (a == 0) ? 4'h3 : 4'hC, 0, refLoad(32'h8001FFFE, 2'(a), 1'b1, 1'b0), 0);
    end

    misalignTest("lh mis", 1'b1, 32'h101);
    misalignTest("lw mis", 1'b0, 32'h102);

    doAccess("ll",  1,0,0,0,0,1, 32'h300, 0, 32'h11112222, 0, 1,0, 32'h300, 4'hF, 0, 32'h11112222, 0);
    doAccess("sc",  0,1,0,0,0,1, 32'h300, 32'h55, 0, 0, 1,1, 32'h300, 4'hF, 32'h55, 32'h1, 0);
    doAccess("sc2", 0,1,0,0,0,1, 32'h300, 32'h66, 0, 0, 0,1, 0, 0, 0, 32'h0, 0);
    doAccess("ll2", 1,0,0,0,0,1, 32'h300, 0, 32'h33334444, 0, 1,0, 32'h300, 4'hF, 0, 32'h33334444, 0);
    @(negedge clk); Flush = 1;
    @(negedge clk); Flush = 0;
    doAccess("sc fl", 0,1,0,0,0,1, 32'h300, 32'h77, 0, 0, 0,1, 0, 0, 0, 32'h0, 0);
    doAccess("ll5", 1,0,0,0,0,1, 32'h500, 0, 32'h5, 0, 1,0, 32'h500, 4'hF, 0, 32'h5, 0);
    doAccess("sw5", 0,1,0,0,0,0, 32'h500, 32'h9, 0, 0, 1,1, 32'h500, 4'hF, 32'h9, 32'h0, 0);
    doAccess("sc5", 0,1,0,0,0,1, 32'h500, 32'h9, 0, 0, 0,1, 0, 0, 0, 32'h0, 0);
    doAccess("ll6", 1,0,0,0,0,1, 32'h600, 0, 32'h6, 0, 1,0, 32'h600, 4'hF, 0, 32'h6, 0);
    doAccess("sw6", 0,1,0,0,0,0, 32'h604, 32'hA, 0, 0, 1,1, 32'h604, 4'hF, 32'hA, 32'h0, 0);
    doAccess("sc6", 0,1,0,0,0,1, 32'h600, 32'hB, 0, 1, 1,1, 32'h600, 4'hF, 32'hB, 32'h1, 0);

    doAccess("hold", 1,0,0,0,0,0, 32'h700, 0, 32'hCAFEF00D, 0, 1,0, 32'h700, 4'hF, 0, 32'hCAFEF00D, 3);

    // Flush while waiting for ack: transaction completes, result dropped, no DONE.
    @(negedge clk);
    MemRead = 1; ALUResult = 32'h400;
    @(posedge clk); @(negedge clk); #1;
    Flush = 1;
    checkVal("flw req1", {31'd0, bus_req}, 32'd1);
    @(posedge clk); @(negedge clk); #1;
    checkVal("flw req2", {31'd0, bus_req}, 32'd1);
    bus_ack = 1; bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus_ack = 0;
    clearInputs();
    @(negedge clk); #1;
    checkVal("flw req3", {31'd0, bus_req}, 32'd0);
    checkVal("flw stall", {31'd0, StallController}, 32'd0);
    checkVal("flw rdata", MemReadData, lastExp);
    doAccess("after flw", 1,0,0,0,0,0, 32'h404, 0, 32'h0BADF00D, 0, 1,0, 32'h404, 4'hF, 0, 32'h0BADF00D, 0);

    // Reset asserted while waiting for ack.
    @(negedge clk);
    MemRead = 1; ALUResult = 32'h800;
    @(posedge clk); @(negedge clk); #1;
    checkVal("rstw req1", {31'd0, bus_req}, 32'd1);
    #1 rst_n = 0;
    clearInputs();
    #1;
    checkVal("rstw req0", {31'd0, bus_req}, 32'd0);
    checkVal("rstw stall", {31'd0, StallController}, 32'd0);
    checkVal("rstw rdata", MemReadData, 32'd0);
    @(negedge clk); rst_n = 1;
    lastExp = 32'd0;
    doAccess("rstw sc", 0,1,0,0,0,1, 32'h600, 32'h1, 0, 0, 0,1, 0, 0, 0, 32'h0, 0);

    checkVal("queue empty", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
